// File: rtl/exec_seq.sv
// exec_seq: multi-cycle execution sequencer for the CPU datapath.
// Holds the PC, starts and awaits the ALU, and issues the data-memory and
// register write strobes in separate phases. A sticky trap is raised on an
// ALU error or when the ALU fails to answer within ALU_TIMEOUT cycles.
//
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   run             enable instruction execution
//   alu_multi       current instruction uses a multi-cycle ALU op
//   mem_rd          current instruction is a load
//   dmem_we_in      raw data-memory write strobe from control
//   reg_we_in       raw register write strobe from control
//   alu_done        ALU result valid
//   alu_error       ALU error (valid with alu_done)
//   alu_emsg        ALU error code (valid with alu_done)
//   alu_start       one-cycle ALU start pulse
//   pc_en           PC advance enable, one cycle per retired instruction
//   dmem_we         gated data-memory write
//   reg_we          gated register write
//   busy            instruction in flight
//   trap            sticky fault indicator
//   trap_code       {timeout, emsg[1:0]}
//   retired         retired-instruction count
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | not executing, waiting for run
// EXEC     | instruction decoded; launches ALU if multi-cycle
// ALU_WAIT | waiting for alu_done, timeout counter running
// MEM      | data-memory phase, dmem_we allowed
// WB       | write-back phase, reg_we and pc_en allowed, retire
// TRAP     | sticky fault, left only through rst

module exec_seq #(
  parameter int ALU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             alu_multi,
  input  logic             mem_rd,
  input  logic             dmem_we_in,
  input  logic             reg_we_in,
  input  logic             alu_done,
  input  logic             alu_error,
  input  logic [1:0]       alu_emsg,
  output logic             alu_start,
  output logic             pc_en,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             busy,
  output logic             trap,
  output logic [2:0]       trap_code,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_ALU_WAIT,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  // Counter only needs to reach ALU_TIMEOUT-1.
  localparam int TW = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(ALU_TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] cnt;
  logic          need_mem;

  assign need_mem = mem_rd | dmem_we_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      trap_code <= '0;
      retired   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) state <= S_EXEC;
        end
        S_EXEC: begin
          if (alu_multi) begin
            cnt   <= '0;
            state <= S_ALU_WAIT;
          end else if (need_mem) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_ALU_WAIT: begin
          if (alu_done) begin
            if (alu_error) begin
              trap_code <= {1'b0, alu_emsg};
              state     <= S_TRAP;
            end else if (need_mem) begin
              state <= S_MEM;
            end else begin
              state <= S_WB;
            end
          end else if (cnt == T_LAST) begin
            // Last allowed wait cycle without alu_done: give up.
            trap_code <= 3'b100;
            state     <= S_TRAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MEM: begin
          state <= S_WB;
        end
        S_WB: begin
          retired <= retired + 1'b1;
          state   <= run ? S_EXEC : S_IDLE;
        end
        S_TRAP: begin
          state <= S_TRAP;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are masked while rst is high so an abandoned instruction
  // never writes anything in the reset cycle.
  assign alu_start = !rst && (state == S_EXEC) && alu_multi;
  assign dmem_we   = !rst && (state == S_MEM) && dmem_we_in;
  assign reg_we    = !rst && (state == S_WB) && reg_we_in;
  assign pc_en     = !rst && (state == S_WB);
  assign busy      = (state == S_EXEC) || (state == S_ALU_WAIT) ||
                     (state == S_MEM) || (state == S_WB);
  assign trap      = (state == S_TRAP);

endmodule

// File: tb/tb_exec_seq.sv
// Directed self-checking bench for exec_seq.
module tb_exec_seq;

  logic        clk;
  logic        rst;
  logic        run;
  logic        alu_multi;
  logic        mem_rd;
  logic        dmem_we_in;
  logic        reg_we_in;
  logic        alu_done;
  logic        alu_error;
  logic [1:0]  alu_emsg;
  logic        alu_start;
  logic        pc_en;
  logic        dmem_we;
  logic        reg_we;
  logic        busy;
  logic        trap;
  logic [2:0]  trap_code;
  logic [31:0] retired;

  int tests;
  int fails;

  exec_seq #(.ALU_TIMEOUT(64), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .alu_multi  (alu_multi),
    .mem_rd     (mem_rd),
    .dmem_we_in (dmem_we_in),
    .reg_we_in  (reg_we_in),
    .alu_done   (alu_done),
    .alu_error  (alu_error),
    .alu_emsg   (alu_emsg),
    .alu_start  (alu_start),
    .pc_en      (pc_en),
    .dmem_we    (dmem_we),
    .reg_we     (reg_we),
    .busy       (busy),
    .trap       (trap),
    .trap_code  (trap_code),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe vector {alu_start, pc_en, dmem_we, reg_we, busy, trap}
  function automatic logic [31:0] strobes();
    return {26'd0, alu_start, pc_en, dmem_we, reg_we, busy, trap};
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; run = 1'b0; alu_multi = 1'b0; mem_rd = 1'b0;
    dmem_we_in = 1'b0; reg_we_in = 1'b0; alu_done = 1'b0;
    alu_error = 1'b0; alu_emsg = 2'b00;

    // Reset state
    cyc(); cyc();
    chk("rst_strobes", strobes(), 32'h0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_code", {29'd0, trap_code}, 32'd0);

    // ALU add, run held 1: EXEC/WB alternate
    rst = 1'b0; run = 1'b1; reg_we_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("add_exec", strobes(), 32'b000010);
      chk("add_exec_ret", retired, 32'(i));
      cyc();
      chk("add_wb", strobes(), 32'b010110);
    end
    cyc();
    chk("add_ret3", retired, 32'd3);
    chk("add_exec4", strobes(), 32'b000010);
    // Drop run mid-instruction: it still completes
    run = 1'b0;
    cyc();
    chk("add_wb4", strobes(), 32'b010110);
    cyc();
    chk("add_idle", strobes(), 32'h0);
    chk("add_ret4", retired, 32'd4);

    // Load: EXEC -> MEM -> WB
    run = 1'b1; mem_rd = 1'b1; reg_we_in = 1'b1;
    cyc();
    chk("ld_exec", strobes(), 32'b000010);
    run = 1'b0;
    cyc();
    chk("ld_mem", strobes(), 32'b000010);
    cyc();
    chk("ld_wb", strobes(), 32'b010110);
    cyc();
    chk("ld_idle", strobes(), 32'h0);
    chk("ld_ret", retired, 32'd5);
    mem_rd = 1'b0;

    // Store: dmem_we only in MEM
    run = 1'b1; dmem_we_in = 1'b1; reg_we_in = 1'b0;
    cyc();
    chk("st_exec", strobes(), 32'b000010);
    run = 1'b0;
    cyc();
    chk("st_mem", strobes(), 32'b001010);
    cyc();
    chk("st_wb", strobes(), 32'b010010);
    cyc();
    chk("st_ret", retired, 32'd6);
    dmem_we_in = 1'b0;

    // Multi-cycle op, done on 5th wait cycle; pc_en on cycle 7
    run = 1'b1; alu_multi = 1'b1; reg_we_in = 1'b1;
    cyc();
    chk("mc_exec", strobes(), 32'b100010);
    run = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("mc_wait", strobes(), 32'b000010);
    end
    alu_done = 1'b1;
    cyc();
    alu_done = 1'b0;
    #1;
    chk("mc_wb", strobes(), 32'b010110);
    cyc();
    chk("mc_idle", strobes(), 32'h0);
    chk("mc_ret", retired, 32'd7);

    // ALU error trap
    run = 1'b1; alu_multi = 1'b1;
    cyc();
    cyc();
    alu_done = 1'b1; alu_error = 1'b1; alu_emsg = 2'b01;
    #1;
    chk("err_wait", strobes(), 32'b000010);
    cyc();
    alu_done = 1'b0; alu_error = 1'b0; alu_emsg = 2'b00;
    #1;
    chk("err_trap", strobes(), 32'b000001);
    chk("err_code", {29'd0, trap_code}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("err_sticky", strobes(), 32'b000001);
      chk("err_code_hold", {29'd0, trap_code}, 32'd1);
    end
    chk("err_ret", retired, 32'd7);
    rst = 1'b1;
    cyc();
    rst = 1'b0; run = 1'b0;
    #1;
    chk("err_rst", strobes(), 32'h0);
    chk("err_rst_code", {29'd0, trap_code}, 32'd0);
    chk("err_rst_ret", retired, 32'd0);

    // Timeout: 64 wait cycles then trap 100
    run = 1'b1; alu_multi = 1'b1; reg_we_in = 1'b0;
    cyc();
    run = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      cyc();
      chk("to_wait", strobes(), 32'b000010);
    end
    cyc();
    chk("to_trap", strobes(), 32'b000001);
    chk("to_code", {29'd0, trap_code}, 32'd4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // Done on the 64th wait cycle wins over timeout
    run = 1'b1;
    cyc();
    run = 1'b0;
    for (int k = 1; k <= 64; k++) cyc();
    alu_done = 1'b1;
    #1;
    chk("to64_wait", strobes(), 32'b000010);
    cyc();
    alu_done = 1'b0;
    #1;
    chk("to64_wb", strobes(), 32'b010010);
    chk("to64_code", {29'd0, trap_code}, 32'd0);
    cyc();
    chk("to64_ret", retired, 32'd1);

    // Reset mid-wait
    run = 1'b1;
    cyc();
    run = 1'b0;
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rstw_idle", strobes(), 32'h0);
    cyc();
    chk("rstw_stay", strobes(), 32'h0);

    // Reset in WB: strobes masked, instruction abandoned
    run = 1'b1; alu_multi = 1'b0; reg_we_in = 1'b1;
    cyc();
    cyc();
    chk("rstwb_pre", strobes(), 32'b010110);
    rst = 1'b1;
    #1;
    chk("rstwb_mask", {30'd0, pc_en, reg_we}, 32'd0);
    cyc();
    rst = 1'b0; run = 1'b0;
    #1;
    chk("rstwb_idle", strobes(), 32'h0);
    chk("rstwb_ret", retired, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exec_seq.md
Name: exec_seq

Overview:
Multi-cycle execution sequencer for the CPU datapath: pc, iMem, control, regheap, ALU, dMem and br_unit.
- Holds the PC, starts and awaits the ALU, and issues the data-memory and register write strobes in separate phases, so multi-cycle ALU ops (done-handshake) execute safely.
- Control decode feeds it raw strobes; it emits the gated strobes that drive pc, dMem and regheap.
- Traps sticky on ALU error or ALU timeout.

Parameters:
ALU_TIMEOUT, 64, max cycles spent in ALU_WAIT before timeout trap (>=2)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
run  in  1  enable instruction execution
alu_multi  in  1  current instruction uses multi-cycle ALU op (from control)
mem_rd  in  1  current instruction is a load (control c3)
dmem_we_in  in  1  raw data-memory write strobe from control
reg_we_in  in  1  raw register write strobe from control
alu_done  in  1  ALU result valid, single-cycle pulse or level
alu_error  in  1  ALU error, valid with alu_done
alu_emsg  in  2  ALU error code, valid with alu_done
alu_start  out  1  one-cycle ALU start pulse
pc_en  out  1  PC advance enable (one cycle per retired instruction)
dmem_we  out  1  gated data-memory write
reg_we  out  1  gated register write
busy  out  1  instruction in flight
trap  out  1  sticky fault indicator
trap_code  out  3  {timeout, emsg[1:0]}
retired  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, EXEC, ALU_WAIT, MEM, WB, TRAP. Reset has priority in every state including TRAP: state=IDLE, retired=0, trap_code=0, timeout counter=0.
- Outputs are decoded from current state plus current inputs, with no extra register stage. All outputs are 0 in IDLE.
- IDLE: if run=1, next state is EXEC; otherwise stay.
- EXEC (1 cycle; instruction is stable because PC is held):
  - alu_multi=1: alu_start=1 this cycle, timeout counter cleared, go to ALU_WAIT.
  - Else if mem_rd|dmem_we_in: go to MEM.
  - Else: go to WB.
  - alu_done is ignored in EXEC.
- ALU_WAIT:
  - alu_done=1 and alu_error=1: go to TRAP, trap_code={1'b0, alu_emsg}.
  - alu_done=1 and alu_error=0: go to MEM if mem_rd|dmem_we_in, else WB.
  - alu_done=0: counter++. If counter==ALU_TIMEOUT-1, go to TRAP with trap_code=3'b100.
  - State therefore lasts at most ALU_TIMEOUT cycles. alu_done on the final count cycle wins over timeout.
- MEM (1 cycle): dmem_we=dmem_we_in; go to WB.
- WB (1 cycle):
  - reg_we=reg_we_in, pc_en=1, retired<=retired+1 (wraps modulo 2^CNT_W).
  - Next state is EXEC if run=1, else IDLE.
- TRAP: trap=1. All strobes, alu_start and busy are 0. trap_code holds its value. run is ignored; only rst exits.
- busy=1 in EXEC, ALU_WAIT, MEM and WB.
- run deasserted mid-instruction: the current instruction completes through WB; only the next fetch stops.
- dmem_we and reg_we are never high outside MEM and WB respectively. pc_en is never high outside WB.
- Reset mid-instruction: no strobe is issued in the reset cycle, and the instruction is abandoned.
- trap_code is 0 whenever trap=0.

Test Plan:
- ALU add, run held 1: after reset, pc_en pulses every 2 cycles (EXEC, WB); reg_we follows reg_we_in; dmem_we=0; retired=3 after 3 pulses.
- Load (mem_rd=1, reg_we_in=1): EXEC → MEM → WB; pc_en and reg_we high only on the 3rd cycle; dmem_we=0.
- Store (dmem_we_in=1, reg_we_in=0): dmem_we high exactly in MEM (cycle 2), reg_we=0, pc_en in cycle 3.
- Multi-cycle op, alu_done after 5 ALU_WAIT cycles: alu_start single pulse in EXEC; pc_en 7 cycles after EXEC entry; no strobes during wait.
- ALU error (done=1, error=1, emsg=2'b01): trap=1, trap_code=3'b001, no reg_we or pc_en; stays trapped with run=1 until rst, after which trap=0, trap_code=0 and retired=0.
- Timeout (ALU_TIMEOUT=64, done never): trap_code=3'b100 after exactly 64 ALU_WAIT cycles. Variant with done on the 64th cycle: no trap, normal WB. Variant with rst mid-wait: IDLE next cycle, busy=0.
